// File: rtl/uart_rx_receiver_if.sv
// Serial-line side and received-byte side of the UART receiver.
// The receiver attaches through the slave modport; whatever drives the line and the tick uses master.
interface uart_rx_receiver_if;
  logic       RxD;
  logic       Rx_sample_ENABLE;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_BUSY;
  logic [2:0] rx_state;

  modport slave (
    input  RxD,
    input  Rx_sample_ENABLE,
    output Rx_DATA,
    output Rx_VALID,
    output Rx_PERROR,
    output Rx_FERROR,
    output Rx_BUSY,
    output rx_state
  );

  modport master (
    output RxD,
    output Rx_sample_ENABLE,
    input  Rx_DATA,
    input  Rx_VALID,
    input  Rx_PERROR,
    input  Rx_FERROR,
    input  Rx_BUSY,
    input  rx_state
  );
endinterface

// File: rtl/uart_rx_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, parity, stop.
// Recovers the byte, checks parity and framing, and strobes Rx_VALID on a clean frame.
module uart_rx_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic reset,
  uart_rx_receiver_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic          rxd_m;
  logic          rxd_s;
  logic          prev_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          perror_q;
  logic          ferror_q;
  logic          busy_q;

  // RxD is asynchronous to clk; idle-high reset values avoid a spurious start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= bus.RxD;
      rxd_s <= rxd_m;
    end
  end

  // Rx_VALID is a one-clk strobe with no ready: the consumer must take Rx_DATA
  // on the cycle Rx_VALID is high; Rx_DATA then holds until the next frame ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prev_s   <= 1'b1;
      cnt      <= '0;
      idx      <= 3'd0;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      perror_q <= 1'b0;
      ferror_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.Rx_sample_ENABLE) begin
        prev_s <= rxd_s;
        unique case (state)
          IDLE: begin
            // Requiring a high-to-low transition keeps a stuck-low line from re-triggering.
            if (!rxd_s && prev_s) begin
              state  <= START;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
          START: begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              idx <= 3'd0;
              if (!rxd_s) begin
                state <= DATA;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              shreg[idx] <= rxd_s;
              if (idx == 3'd7) begin
                state <= PARITY;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          PARITY: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              par_bit <= rxd_s;
              state   <= STOP;
            end
          end
          STOP: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              data_q   <= shreg;
              perror_q <= (^shreg) ^ par_bit ^ PARITY_ODD;
              ferror_q <= ~rxd_s;
              valid_q  <= ~((^shreg) ^ par_bit ^ PARITY_ODD) & rxd_s;
              state    <= IDLE;
              busy_q   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Rx_DATA   = data_q;
  assign bus.Rx_VALID  = valid_q;
  assign bus.Rx_PERROR = perror_q;
  assign bus.Rx_FERROR = ferror_q;
  assign bus.Rx_BUSY   = busy_q;
  assign bus.rx_state  = state;

endmodule

// File: doc/uart_rx_receiver.md
# uart_rx_receiver

Serial receiver for the team's UART link. It is the far end of the transmitter that shifts out an 11-bit packet, least-significant bit first: start (0), D0..D7, even parity, stop (1). The block oversamples RxD at 16× the baud rate using the shared baud-rate generator's sample-enable pulse. It recovers the data byte, checks parity and framing, and presents the byte with a one-cycle valid strobe to the 7-segment display path.

## Interface
- OVERSAMPLE, 16: sample-enable ticks per bit; must be a power of 2, ≥ 8.
- PARITY_ODD, 0: 0 = even parity expected, 1 = odd parity expected.

Ports. Clock is `clk`; reset is `reset`, asynchronous and active-high.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
- RxD  input  1  serial line; idle high; asynchronous to `clk`.
- Rx_sample_ENABLE  input  1  single-`clk` pulse at OVERSAMPLE × baud.
- Rx_DATA  output  8  last received byte; reset 8'h00.
- Rx_VALID  output  1  one-`clk` pulse on an error-free frame; reset 0.
- Rx_PERROR  output  1  parity error of last frame; reset 0.
- Rx_FERROR  output  1  framing error of last frame; reset 0.
- Rx_BUSY  output  1  high while a frame is in progress; reset 0.

## Operation
- RxD passes through a 2-flop synchronizer (reset value 1) to give `rxd_s`. All decisions use `rxd_s`.
- `rxd_s` is sampled only on clocks where Rx_sample_ENABLE = 1.
- Register `prev_s` (reset 1) holds the `rxd_s` value from the previous tick.
- There is a tick counter `cnt`, log2(OVERSAMPLE) bits wide, and a bit index `idx` of 3 bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with `rxd_s` = 0 and `prev_s` = 1, go to START with `cnt` = 0. A line held low never triggers a new start.
- START: `cnt` increments each tick. On the tick where `cnt` = OVERSAMPLE/2−1 (mid start bit):
  - `rxd_s` = 0: go to DATA with `cnt` = 0 and `idx` = 0.
  - `rxd_s` = 1: false start; go to IDLE and leave all outputs unchanged.
- DATA: on the tick where `cnt` = OVERSAMPLE−1, the sample goes into shift register bit `idx` and `cnt` clears. When `idx` = 7, go to PARITY; otherwise `idx` increments.
- PARITY: on the tick where `cnt` = OVERSAMPLE−1, store the parity bit p and go to STOP.
- STOP: on the tick where `cnt` = OVERSAMPLE−1, take the stop sample, complete the frame, and go to IDLE.
- Frame completion happens in a single clock:
  - Rx_DATA ← shift register (loaded even on error).
  - Rx_PERROR ← (^data ^ p ^ PARITY_ODD) ≠ 0.
  - Rx_FERROR ← (stop sample = 0).
  - Rx_VALID ← 1 only if both flags are 0.
- Rx_PERROR and Rx_FERROR hold until the next frame completion or reset. A false start does not clear them.
- Rx_BUSY = 1 in every state except IDLE; it is registered with the state.
- Back-to-back frames: IDLE can detect a start on the tick right after the stop sample, provided `prev_s` = 1.
- Reset at any point: state goes to IDLE and all outputs to their reset values. Any partial frame is discarded.

## Timing
- RxD-to-`rxd_s` latency is 2 `clk` cycles.
- Start detection happens on the first tick at which `rxd_s` is low.
- Data-bit sample points fall at 1.5, 2.5, … bit periods after that tick, all within ±1 tick of the true bit centre.
- Rx_VALID rises on the clock edge that processes the stop-sample tick and is high for exactly one `clk` cycle. Rx_DATA and both error flags update on the same edge.
- Rx_BUSY rises one `clk` after the start-detect tick. It falls on the false-start edge or the stop-sample edge.
- A tick arriving in the same clock as reset deassertion is ignored.
- A frame spans 10.5 bit periods from start edge to stop sample. Maximum throughput is one byte per 11 bit periods.

## Test plan
- 0xA5 frame, parity 0, stop 1, with OVERSAMPLE = 16 ticks per bit → Rx_DATA = 8'hA5, one Rx_VALID pulse, Rx_PERROR = Rx_FERROR = 0, Rx_BUSY low afterwards.
- 0x01 frame with parity bit 0 (wrong under even parity) → Rx_DATA = 8'h01, Rx_PERROR = 1, Rx_FERROR = 0, no Rx_VALID. A following correct 0x02 frame clears Rx_PERROR and pulses Rx_VALID.
- 0x3C frame with stop bit 0, then the line returned high → Rx_FERROR = 1, no Rx_VALID. The next start is detected only after the line has been high for one or more ticks.
- RxD low for 4 ticks, then high → Rx_BUSY high for about 8 ticks, return to IDLE, no Rx_VALID, Rx_DATA and error flags unchanged.
- Reset asserted during data bit 3 of a 0xFF frame → all outputs at reset values immediately. After release, a clean 0x5A frame yields Rx_DATA = 8'h5A with one Rx_VALID pulse.
- Back-to-back frames 0xFF then 0x00 with zero idle gap (stop bit directly followed by start bit) → two Rx_VALID pulses about 11 bit periods apart, Rx_DATA = 8'hFF then 8'h00, no errors.
